// File: rtl/seq_detector_n.sv
// Serial N-bit pattern detector with runtime pattern, overlap and Mealy/Moore
// selection, input qualification and a saturating match counter.
module seq_detector_n #(
   parameter int N       = 3,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [N-1:0]       cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               cfg_moore,
   input  logic               x_valid,
   input  logic               x,
   input  logic               cnt_clear,
   output logic               y,
   output logic [COUNT_W-1:0] match_count,
   output logic               armed
);

   localparam int FW = $clog2(N);
   localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      UNARMED = 1'b0,
      ARMED   = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N-2:0]         r_hist;
   logic [FW-1:0]        r_fill;
   logic [N-1:0]         r_pat;
   logic                 r_ovl;
   logic                 r_moore;
   logic                 r_y;
   logic [COUNT_W-1:0]   r_cnt;
   logic [N-1:0]         w_cat;
   logic                 w_accept;
   logic                 w_hit;

   // history plus the bit arriving this cycle, oldest bit at the MSB
   assign w_cat    = {r_hist, x};
   assign w_accept = x_valid & (r_state == ARMED) & ~cfg_load;
   assign w_hit    = w_accept & (r_fill == FILL_MAX) & (w_cat == r_pat);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= UNARMED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (cfg_load) begin
         w_state_nxt = ARMED;
      end
   end

   always_comb begin
      armed = (r_state == ARMED);
      y     = r_moore ? r_y : w_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pat   <= '0;
         r_ovl   <= 1'b0;
         r_moore <= 1'b0;
      end else if (cfg_load) begin
         r_pat   <= cfg_pattern;
         r_ovl   <= cfg_overlap;
         r_moore <= cfg_moore;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (cfg_load) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (w_accept) begin
         r_hist <= w_cat[N-2:0];
         if (w_hit && !r_ovl) begin
            r_fill <= '0;
         end else if (r_fill != FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
         r_y <= 1'b0;
      end else begin
         r_y <= w_hit & r_moore;
      end
   end

   // clear beats a simultaneous hit
   always_ff @(posedge clk) begin
      if (reset || cnt_clear) begin
         r_cnt <= '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: a 3-bit/8-bit-count instance and a 2-bit/2-bit-count
// instance share stimulus and are checked against a bit-string reference model.
module tb_seq_detector_n;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_load = 1'b0;
   logic [2:0] cfg_pattern = '0;
   logic       cfg_overlap = 1'b0;
   logic       cfg_moore = 1'b0;
   logic       x_valid = 1'b0;
   logic       x = 1'b0;
   logic       cnt_clear = 1'b0;

   logic       ya, arma, yb, armb;
   logic [7:0] cnta;
   logic [1:0] cntb;

   int n_chk = 0;
   int n_pass = 0;

   int m_armed[2], m_pat[2], m_ovl[2], m_moore[2];
   int m_yreg[2], m_cnt[2], m_fresh[2], m_hv[2];
   int e_y[2], e_cnt[2], e_arm[2];

   always #5 clk = ~clk;

   seq_detector_n #(.N(3), .COUNT_W(8)) u_a (
      .clk(clk), .reset(reset), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
      .cfg_moore(cfg_moore), .x_valid(x_valid), .x(x),
      .cnt_clear(cnt_clear), .y(ya), .match_count(cnta), .armed(arma)
   );

   seq_detector_n #(.N(2), .COUNT_W(2)) u_b (
      .clk(clk), .reset(reset), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern[1:0]), .cfg_overlap(cfg_overlap),
      .cfg_moore(cfg_moore), .x_valid(x_valid), .x(x),
      .cnt_clear(cnt_clear), .y(yb), .match_count(cntb), .armed(armb)
   );

   // Drive one cycle at the falling edge, publish what each DUT should show
   // before the next rising edge, then advance the model past that edge.
   task automatic drive(input bit rs, input bit ld, input logic [2:0] p,
                        input bit ov, input bit mo, input bit v,
                        input bit xb, input bit cl);
      @(negedge clk);
      reset = rs; cfg_load = ld; cfg_pattern = p; cfg_overlap = ov;
      cfg_moore = mo; x_valid = v; x = xb; cnt_clear = cl;
      #1;
      for (int d = 0; d < 2; d++) begin
         int n, mx, acc, hit;
         n   = (d == 0) ? 3 : 2;
         mx  = (d == 0) ? 255 : 3;
         acc = (v && m_armed[d] && !ld) ? 1 : 0;
         hit = (acc != 0 && m_fresh[d] >= n - 1 &&
                (m_hv[d] * 2 + int'(xb)) == m_pat[d]) ? 1 : 0;
         e_y[d]   = (m_moore[d] != 0) ? m_yreg[d] : hit;
         e_cnt[d] = m_cnt[d];
         e_arm[d] = m_armed[d];
         if (rs) begin
            m_armed[d] = 0; m_pat[d] = 0; m_ovl[d] = 0; m_moore[d] = 0;
            m_yreg[d] = 0; m_cnt[d] = 0; m_fresh[d] = 0; m_hv[d] = 0;
         end else begin
            if (cl) m_cnt[d] = 0;
            else if (hit != 0 && m_cnt[d] < mx) m_cnt[d] = m_cnt[d] + 1;
            m_yreg[d] = (!ld && hit != 0 && m_moore[d] != 0) ? 1 : 0;
            if (ld) begin
               m_armed[d] = 1;
               m_pat[d]   = int'(p) % (1 << n);
               m_ovl[d]   = int'(ov);
               m_moore[d] = int'(mo);
               m_fresh[d] = 0;
               m_hv[d]    = 0;
            end else if (acc != 0) begin
               if (hit != 0 && m_ovl[d] == 0) begin
                  m_fresh[d] = 0;
               end else begin
                  m_fresh[d] = m_fresh[d] + 1;
               end
               m_hv[d] = (m_hv[d] * 2 + int'(xb)) % (1 << (n - 1));
            end
         end
      end
   endtask

   task automatic idle();
      drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
   endtask

   task automatic bit_in(input bit xb);
      drive(0, 0, 3'b000, 0, 0, 1, xb, 0);
   endtask

   task automatic test_reset();
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 0, 3'b000, 0, 0, 1, 1, 0);
      n_chk++;
      if (ya !== 1'b0 || arma !== 1'b0 || cnta !== 8'd0 ||
          yb !== 1'b0 || armb !== 1'b0 || cntb !== 2'd0)
         $display("FAIL reset: a y=%b arm=%b cnt=%0d b y=%b arm=%b cnt=%0d required all 0",
                  ya, arma, cnta, yb, armb, cntb);
      else n_pass++;
   endtask

   task automatic test_overlap_mealy();
      int s[5] = '{1, 0, 1, 0, 1};
      int ey[5] = '{0, 0, 1, 0, 1};
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b101, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         bit_in(s[i][0]);
         n_chk++;
         if (ya !== ey[i][0] || ya !== e_y[0][0])
            $display("FAIL overlap_y bit%0d: got %b required %0d", i + 1, ya, ey[i]);
         else n_pass++;
      end
      idle();
      n_chk++;
      if (cnta !== 8'd2 || arma !== 1'b1)
         $display("FAIL overlap_cnt: got %0d arm %b required 2 arm 1", cnta, arma);
      else n_pass++;
   endtask

   task automatic test_nonoverlap();
      int s[7] = '{1, 0, 1, 0, 1, 0, 1};
      int ey[7] = '{0, 0, 1, 0, 0, 0, 1};
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b101, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         bit_in(s[i][0]);
         n_chk++;
         if (ya !== ey[i][0] || ya !== e_y[0][0])
            $display("FAIL nonoverlap_y bit%0d: got %b required %0d", i + 1, ya, ey[i]);
         else n_pass++;
         if (i == 5) begin
            n_chk++;
            if (cnta !== 8'd1)
               $display("FAIL nonoverlap_cnt1: got %0d required 1", cnta);
            else n_pass++;
         end
      end
      idle();
      n_chk++;
      if (cnta !== 8'd2)
         $display("FAIL nonoverlap_cnt2: got %0d required 2", cnta);
      else n_pass++;
   endtask

   task automatic test_moore_gap();
      int v[8]  = '{1, 0, 0, 0, 1, 1, 0, 0};
      int s[8]  = '{1, 0, 0, 0, 0, 1, 0, 0};
      int ey[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      int ec[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b101, 1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 3'b000, 0, 0, v[i][0], s[i][0], 0);
         n_chk++;
         if (ya !== ey[i][0] || cnta !== 8'(ec[i]) || ya !== e_y[0][0])
            $display("FAIL moore_gap cyc%0d: y=%b cnt=%0d required y=%0d cnt=%0d",
                     i, ya, cnta, ey[i], ec[i]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int ec[7] = '{0, 0, 1, 2, 3, 3, 3};
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b011, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 3'b000, 0, 0, 1, 1, (i == 6) ? 1'b1 : 1'b0);
         n_chk++;
         if (cntb !== 2'(ec[i]) || yb !== ((i > 0) ? 1'b1 : 1'b0))
            $display("FAIL sat cyc%0d: cnt=%0d y=%b required cnt=%0d", i, cntb, yb, ec[i]);
         else n_pass++;
      end
      idle();
      n_chk++;
      if (cntb !== 2'd0)
         $display("FAIL sat_clear: got %0d required 0", cntb);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b101, 1, 0, 0, 0, 0);
      bit_in(1);
      bit_in(0);
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         bit_in((i == 1) ? 1'b0 : 1'b1);
         n_chk++;
         if (ya !== 1'b0 || arma !== 1'b0 || cnta !== 8'd0)
            $display("FAIL reset_mid cyc%0d: y=%b arm=%b cnt=%0d required 0 0 0",
                     i, ya, arma, cnta);
         else n_pass++;
      end
   endtask

   task automatic test_reload();
      int s[3] = '{0, 1, 0};
      int ey[3] = '{0, 0, 1};
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'b101, 1, 0, 0, 0, 0);
      bit_in(1);
      bit_in(0);
      drive(0, 1, 3'b010, 1, 0, 1, 1, 0);
      n_chk++;
      if (ya !== 1'b0)
         $display("FAIL reload_ldcyc: got %b required 0", ya);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         bit_in(s[i][0]);
         n_chk++;
         if (ya !== ey[i][0])
            $display("FAIL reload_y bit%0d: got %b required %0d", i + 1, ya, ey[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
      drive(0, 1, 3'($urandom), 1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit rs, ld, cl, v;
         rs = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 39) == 0);
         cl = ($urandom_range(0, 49) == 0);
         v  = ($urandom_range(0, 3) != 0);
         drive(rs, ld, 3'($urandom), 1'($urandom), 1'($urandom), v,
               1'($urandom), cl);
         if (rs) drive(0, 1, 3'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
         n_chk++;
         if (ya !== e_y[0][0] || cnta !== 8'(e_cnt[0]) || arma !== e_arm[0][0] ||
             yb !== e_y[1][0] || cntb !== 2'(e_cnt[1]) || armb !== e_arm[1][0])
            $display("FAIL random cyc%0d: a y/cnt/arm=%b/%0d/%b req %0d/%0d/%0d b %b/%0d/%b req %0d/%0d/%0d",
                     i, ya, cnta, arma, e_y[0], e_cnt[0], e_arm[0],
                     yb, cntb, armb, e_y[1], e_cnt[1], e_arm[1]);
         else n_pass++;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_armed[d] = 0; m_pat[d] = 0; m_ovl[d] = 0; m_moore[d] = 0;
         m_yreg[d] = 0; m_cnt[d] = 0; m_fresh[d] = 0; m_hv[d] = 0;
      end
      test_reset();
      test_overlap_mealy();
      test_nonoverlap();
      test_moore_gap();
      test_saturation();
      test_reset_mid();
      test_reload();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
